// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital-clock mode/time-base controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    localparam logic [2:0] BLINK_RST = 3'b111;

    // Display-enable mask {hour, min, sec}: the field being edited follows the phase.
    function automatic logic [2:0] blink_mask(input mode_t m, input logic phase);
        logic [2:0] mask;
        mask = BLINK_RST;
        case (m)
            SET_HOUR: mask[2] = phase;
            SET_MIN:  mask[1] = phase;
            SET_SEC:  mask[0] = phase;
            default:  mask = BLINK_RST;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Button, carry and pulse signals between the clock controller and its neighbours.
interface clock_ctrl_if;
    logic       mode_btn;
    logic       inc_btn;
    logic       sec_carry;
    logic       min_carry;
    logic       sec_tick;
    logic       min_inc;
    logic       hour_inc;
    logic       sec_clr;
    logic [1:0] mode;
    logic [2:0] blink;

    modport master (
        output mode_btn, inc_btn, sec_carry, min_carry,
        input  sec_tick, min_inc, hour_inc, sec_clr, mode, blink
    );

    modport slave (
        input  mode_btn, inc_btn, sec_carry, min_carry,
        output sec_tick, min_inc, hour_inc, sec_clr, mode, blink
    );
endinterface

// File: rtl/clock_ctrl_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and emits a registered one-cycle
// pulse on the terminal count; clr holds the count at 0 and masks the pulse.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic CP,
    input  logic RST,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge CP or negedge RST) begin
        if (!RST) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == TERM) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;
endmodule

// File: rtl/clock_ctrl.sv
// Mode FSM, carry-to-increment chaining and blink mask for the digital clock.
// Blink counter is built only when CLOCK_CTRL_BLINK_EN is defined.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic         CP,
    input  logic         RST,
    clock_ctrl_if.slave  bus
);
    if (TICK_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
        $error("clock_ctrl: TICK_DIV and BLINK_DIV must be >= 2");
    end

    mode_t state_reg, state_next;
    logic  sec_carry_reg, min_carry_reg;
    logic  min_inc_reg, hour_inc_reg, sec_clr_reg;
    logic  min_inc_next, hour_inc_next, sec_clr_next;
    logic  sec_edge, min_edge, inc_ok, run, tick_clr, tick;

    always_comb begin
        state_next = state_reg;
        if (bus.mode_btn) begin
            case (state_reg)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                default:  state_next = RUN;
            endcase
        end
    end

    assign run      = (state_reg == RUN);
    assign sec_edge = bus.sec_carry & ~sec_carry_reg;
    assign min_edge = bus.min_carry & ~min_carry_reg;
    assign inc_ok   = bus.inc_btn & ~bus.mode_btn;

    // Carry pulses depend only on the current state, so an edge coinciding with leaving RUN still counts.
    always_comb begin
        min_inc_next  = (run & sec_edge) | ((state_reg == SET_MIN) & inc_ok);
        hour_inc_next = (run & min_edge) | ((state_reg == SET_HOUR) & inc_ok);
        sec_clr_next  = (state_reg == SET_SEC) & inc_ok;
    end

    always_ff @(posedge CP or negedge RST) begin
        if (!RST) begin
            state_reg     <= RUN;
            sec_carry_reg <= 1'b0;
            min_carry_reg <= 1'b0;
            min_inc_reg   <= 1'b0;
            hour_inc_reg  <= 1'b0;
            sec_clr_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sec_carry_reg <= bus.sec_carry;
            min_carry_reg <= bus.min_carry;
            min_inc_reg   <= min_inc_next;
            hour_inc_reg  <= hour_inc_next;
            sec_clr_reg   <= sec_clr_next;
        end
    end

    // A mode press while in RUN both leaves RUN and swallows a coincident terminal count.
    assign tick_clr = ~run | bus.mode_btn;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CP   (CP),
        .RST  (RST),
        .clr  (tick_clr),
        .tick (tick)
    );

`ifdef CLOCK_CTRL_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_phase_reg, blink_phase_next;
    logic [2:0]    blink_reg;

    always_comb begin
        blink_cnt_next   = blink_cnt_reg + 1'b1;
        blink_phase_next = blink_phase_reg;
        if (state_next != state_reg) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b1;
        end else if (blink_cnt_reg == BLINK_TERM) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    always_ff @(posedge CP or negedge RST) begin
        if (!RST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
            blink_reg       <= BLINK_RST;
        end else begin
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            blink_reg       <= blink_mask(state_next, blink_phase_next);
        end
    end

    assign bus.blink = blink_reg;
`else
    assign bus.blink = BLINK_RST;
`endif

    assign bus.sec_tick = tick;
    assign bus.min_inc  = min_inc_reg;
    assign bus.hour_inc = hour_inc_reg;
    assign bus.sec_clr  = sec_clr_reg;
    assign bus.mode     = state_reg;
endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV=4, BLINK_DIV=3.
module tb_clock_ctrl;
`ifdef CLOCK_CTRL_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    typedef struct {
        logic       mb, ib, sc, mc;
        logic       tk, mi, hi, clr;
        logic [1:0] mode;
        logic [2:0] blink;
    } vec_t;

    logic CP = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    clock_ctrl_if bus ();

    clock_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .CP  (CP),
        .RST (RST),
        .bus (bus)
    );

    always #5 CP = ~CP;

    task automatic v(input logic mb, ib, sc, mc, tk, mi, hi, clr,
                     input logic [1:0] mode, input logic [2:0] blink);
        vec_t r;
        r.mb = mb; r.ib = ib; r.sc = sc; r.mc = mc;
        r.tk = tk; r.mi = mi; r.hi = hi; r.clr = clr;
        r.mode = mode; r.blink = blink;
        vecs.push_back(r);
    endtask

    task automatic check_outs(input string name, input logic [3:0] exp_p,
                              input logic [1:0] exp_mode, input logic [2:0] exp_blink);
        logic [3:0] act_p;
        act_p = {bus.sec_tick, bus.min_inc, bus.hour_inc, bus.sec_clr};
        checks++;
        if (act_p !== exp_p || bus.mode !== exp_mode || bus.blink !== exp_blink) begin
            failures++;
            $display("FAIL %s: got tick/min/hour/clr=%b mode=%0d blink=%b, want %b mode=%0d blink=%b",
                     name, act_p, bus.mode, bus.blink, exp_p, exp_mode, exp_blink);
        end
    endtask

    initial begin
        int first_tick;
        logic [2:0] eb;

        bus.mode_btn = 0; bus.inc_btn = 0; bus.sec_carry = 0; bus.min_carry = 0;

        //   mb ib sc mc | tk mi hi clr | mode blink
        for (int i = 0; i < 3; i++) v(0,0,0,0, 0,0,0,0, 0, 3'b111);   // edges 1-3
        v(0,0,0,0, 1,0,0,0, 0, 3'b111);                               // 4: tick
        for (int i = 0; i < 3; i++) v(0,0,0,0, 0,0,0,0, 0, 3'b111);   // 5-7
        v(0,0,0,0, 1,0,0,0, 0, 3'b111);                               // 8: tick
        v(0,0,1,0, 0,1,0,0, 0, 3'b111);                               // 9: sec carry edge
        v(0,0,0,0, 0,0,0,0, 0, 3'b111);                               // 10
        v(0,0,0,1, 0,0,1,0, 0, 3'b111);                               // 11: min carry edge
        v(0,0,0,0, 1,0,0,0, 0, 3'b111);                               // 12: tick
        v(1,0,0,0, 0,0,0,0, 1, 3'b111);                               // 13: -> SET_HOUR
        v(0,1,0,0, 0,0,1,0, 1, 3'b111);                               // 14: inc
        v(0,0,0,0, 0,0,0,0, 1, 3'b111);                               // 15
        v(0,1,0,0, 0,0,1,0, 1, 3'b011);                               // 16: inc, phase 0
        v(1,1,0,0, 0,0,0,0, 2, 3'b111);                               // 17: mode wins
        v(0,1,0,0, 0,1,0,0, 2, 3'b111);                               // 18: inc -> min
        v(0,0,0,1, 0,0,0,0, 2, 3'b111);                               // 19: carry suppressed
        for (int i = 0; i < 3; i++) v(0,0,0,0, 0,0,0,0, 2, 3'b101);   // 20-22
        v(0,0,0,0, 0,0,0,0, 2, 3'b111);                               // 23
        v(1,0,0,0, 0,0,0,0, 3, 3'b111);                               // 24: -> SET_SEC
        v(0,1,0,0, 0,0,0,1, 3, 3'b111);                               // 25: sec_clr
        v(0,0,0,0, 0,0,0,0, 3, 3'b111);                               // 26
        v(0,0,0,0, 0,0,0,0, 3, 3'b110);                               // 27
        v(1,0,0,0, 0,0,0,0, 0, 3'b111);                               // 28: -> RUN
        for (int i = 0; i < 3; i++) v(0,0,0,0, 0,0,0,0, 0, 3'b111);   // 29-31
        v(0,0,0,0, 1,0,0,0, 0, 3'b111);                               // 32: first tick
        for (int i = 0; i < 3; i++) v(0,0,0,0, 0,0,0,0, 0, 3'b111);   // 33-35
        v(1,0,1,0, 0,1,0,0, 1, 3'b111);                               // 36: tick dropped, carry kept
        v(0,0,0,0, 0,0,0,0, 1, 3'b111);                               // 37
        v(0,0,1,0, 0,0,0,0, 1, 3'b111);                               // 38: carry suppressed
        v(0,0,0,0, 0,0,0,0, 1, 3'b011);                               // 39
        v(1,0,0,0, 0,0,0,0, 2, 3'b111);                               // 40
        v(1,0,0,0, 0,0,0,0, 3, 3'b111);                               // 41
        v(0,1,0,0, 0,0,0,1, 3, 3'b111);                               // 42: sec_clr

        // Reset state
        repeat (2) @(posedge CP);
        #1;
        check_outs("reset_state", 4'b0000, 2'd0, 3'b111);
        RST = 1'b1;

        foreach (vecs[i]) begin
            bus.mode_btn  = vecs[i].mb;
            bus.inc_btn   = vecs[i].ib;
            bus.sec_carry = vecs[i].sc;
            bus.min_carry = vecs[i].mc;
            @(posedge CP);
            #1;
            eb = BLINK_EN ? vecs[i].blink : 3'b111;
            $display("vec %0d: in mb=%b ib=%b sc=%b mc=%b out tick/min/hour/clr=%b%b%b%b mode=%0d blink=%b",
                     i + 1, vecs[i].mb, vecs[i].ib, vecs[i].sc, vecs[i].mc,
                     bus.sec_tick, bus.min_inc, bus.hour_inc, bus.sec_clr, bus.mode, bus.blink);
            check_outs($sformatf("vec%0d", i + 1),
                       {vecs[i].tk, vecs[i].mi, vecs[i].hi, vecs[i].clr}, vecs[i].mode, eb);
        end

        // Asynchronous reset in SET_SEC while sec_clr is high
        bus.mode_btn = 0; bus.inc_btn = 0; bus.sec_carry = 0; bus.min_carry = 0;
        #2;
        RST = 1'b0;
        #1;
        $display("async reset: mode=%0d sec_clr=%b blink=%b", bus.mode, bus.sec_clr, bus.blink);
        check_outs("async_reset", 4'b0000, 2'd0, 3'b111);
        repeat (2) @(posedge CP);
        #1;
        RST = 1'b1;

        first_tick = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CP);
            #1;
            if (bus.sec_tick === 1'b1 && first_tick == 0) first_tick = n;
        end
        $display("post-reset first tick at edge %0d", first_tick);
        checks++;
        if (first_tick != 4) begin
            failures++;
            $display("FAIL first_tick_after_reset: got edge %0d, want edge 4", first_tick);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and time-base controller for the digital-clock datapath. It divides the system clock into a one-second count enable for the BCD seconds counter and chains the counters' carries into minute and hour increment pulses. A button-driven state machine lets the user set hours, minutes and seconds, and it drives a blink mask so the field being edited flashes on the display scanner.

## Interface
Parameters:
- TICK_DIV, 100_000_000: system-clock cycles per second tick; must be ≥ 2.
- BLINK_DIV, 25_000_000: cycles per blink half-period; must be ≥ 2.

Ports:
- CP  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- mode_btn  in  1  single-cycle pulse (already debounced and synchronised); advances the mode.
- inc_btn  in  1  single-cycle pulse (already debounced and synchronised); edits the selected field.
- sec_carry  in  1  level carry from the seconds counter.
- min_carry  in  1  level carry from the minutes counter.
- sec_tick  out  1  one-cycle count enable to the seconds counter.
- min_inc  out  1  one-cycle increment to the minutes counter.
- hour_inc  out  1  one-cycle increment to the hours counter.
- sec_clr  out  1  one-cycle synchronous clear to the seconds counter.
- mode  out  2  current state: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC.
- blink  out  3  display-enable mask {hour, min, sec}; 1 = digit shown.

## Operation
- FSM cycle on mode_btn: RUN → SET_HOUR → SET_MIN → SET_SEC → RUN. With no mode_btn, the state holds.
- RUN:
  - Prescaler counts 0 to TICK_DIV−1 and wraps.
  - sec_tick is asserted once per wrap.
  - A rising edge (0 → 1) on sec_carry produces one min_inc pulse.
  - A rising edge on min_carry produces one hour_inc pulse.
  - inc_btn is ignored.
- SET_HOUR: inc_btn produces hour_inc.
- SET_MIN: inc_btn produces min_inc.
- SET_SEC: inc_btn produces sec_clr, which zeroes the seconds field.
- All SET states:
  - Prescaler is held at 0 and sec_tick stays 0.
  - Carry edge registers keep tracking their inputs, but carry-derived pulses are suppressed. Minute wrap during setting must not bump hours.
- Leaving RUN: the prescaler clears.
- Re-entering RUN: the first sec_tick comes exactly TICK_DIV cycles after the mode change.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: mode_btn wins and inc_btn is dropped.
  - mode_btn in the same cycle as the prescaler terminal count: the tick is suppressed.
  - Carry edge in the same cycle as the exit from RUN: the pulse is still issued, because it was caused in RUN.
- Pulse outputs are mutually independent. min_inc and hour_inc may coincide.
- Reset mid-operation returns everything to reset values immediately and asynchronously. Carry edge registers load 0, so a carry that is high at reset release produces a pulse.

## Timing
- Reset values:
  - mode = 0, blink = 3'b111.
  - sec_tick, min_inc, hour_inc and sec_clr = 0.
  - Prescaler = 0, blink counter = 0, blink phase = 1.
- All outputs are registered.
- Pulse latency is 1 cycle: a cause sampled at edge n gives the output high during cycle n+1, for exactly one cycle.
- mode updates 1 cycle after mode_btn.
- sec_tick period is exactly TICK_DIV cycles. Prescaler width is $clog2(TICK_DIV).
- blink:
  - RUN: 3'b111.
  - SET states: the selected bit equals the blink phase and the other bits are 1.
  - The phase toggles every BLINK_DIV cycles.
  - The counter and phase reset to 0 and 1 on every mode change, so the field is visible immediately.

## Configuration
- CLOCK_CTRL_BLINK_EN defined: blink counter and phase are implemented as described above.
- Not defined:
  - blink is tied to 3'b111.
  - The blink counter is not synthesised.
  - BLINK_DIV is unused.

## Structure
- Package clock_ctrl_pkg holds:
  - the mode enum (RUN, SET_HOUR, SET_MIN, SET_SEC) with 2-bit encoding 0–3;
  - the blink reset constant 3'b111.
- One sub-module, tick_gen. It holds the TICK_DIV prescaler with a clear input and a registered one-cycle terminal pulse.
- FSM, carry edge detection and blink logic stay in clock_ctrl.

## Test plan
Benches use TICK_DIV = 4 and BLINK_DIV = 3.
- Time base: release reset and stay in RUN → sec_tick high in cycles 4, 8, 12 after release; mode = 0; blink = 3'b111.
- Carry chain: raise sec_carry for 1 cycle, then raise min_carry 2 cycles later → one min_inc pulse, then one hour_inc pulse, each 1 cycle after its edge.
- Set sequence:
  - mode_btn → mode = 1, sec_tick stops; inc_btn ×2 → two hour_inc pulses.
  - mode_btn → mode = 2; inc_btn → min_inc.
  - mode_btn → mode = 3; inc_btn → sec_clr.
  - mode_btn → mode = 0; first sec_tick 4 cycles later.
- Suppression and priority:
  - In SET_MIN, raise min_carry → no hour_inc.
  - mode_btn together with inc_btn in SET_HOUR → mode = 2 and no hour_inc.
- Blink: in SET_MIN with the macro defined → blink[1] toggles every 3 cycles starting at 1, other bits stay 1. Without the macro → constant 3'b111.
- Async reset: assert RST mid-count in SET_SEC → mode = 0 and all pulses 0 immediately. First tick comes 4 cycles after release.
